// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage.
// Owns the HI/LO registers. Results are computed combinationally from the
// operands present at the accepting edge and held in pending registers.
// A down-counter then models the latency. The pending value reaches HI/LO
// on the edge where the counter goes from 1 to 0.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Full 64-bit two's-complement product.
    function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ae;
        logic signed [63:0] be;
        logic signed [63:0] p;
        ae = {{32{a[31]}}, a};
        be = {{32{b[31]}}, b};
        p  = ae * be;
        return p;
    endfunction

    // Full 64-bit unsigned product.
    function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae;
        logic [63:0] be;
        ae = {32'b0, a};
        be = {32'b0, b};
        return ae * be;
    endfunction

    // Signed divide returning {remainder, quotient}. Quotient truncates toward
    // zero, remainder carries the dividend's sign. The most-negative / -1 case
    // is pinned explicitly so it cannot depend on tool overflow behaviour.
    // A zero divisor returns 0; the caller suppresses the commit in that case.
    function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] q;
        logic signed [31:0] r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            return 64'd0;
        end
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end
        q = sa / sb;
        r = sa % sb;
        return {r, q};
    endfunction

    // Unsigned divide returning {remainder, quotient}; zero divisor returns 0.
    function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) begin
            return 64'd0;
        end
        return {a % b, a / b};
    endfunction

    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [31:0]      pend_hi_p1;
    logic [31:0]      pend_lo_p1;
    logic             pend_wr_p1;

    logic [63:0]      result_p0;
    logic             result_wr_p0;
    logic             is_long_p0;
    logic             legal_p0;
    logic             accept_p0;

    // Stage 0: decode the request and compute the candidate result from A/B.
    always_comb begin
        result_p0    = 64'd0;
        result_wr_p0 = 1'b1;
        case (MDUOp)
            OP_MULT:  result_p0 = mul_signed(A, B);
            OP_MULTU: result_p0 = mul_unsigned(A, B);
            OP_DIV: begin
                result_p0    = div_signed(A, B);
                result_wr_p0 = (B != 32'd0);
            end
            OP_DIVU: begin
                result_p0    = div_unsigned(A, B);
                result_wr_p0 = (B != 32'd0);
            end
            default: begin
                result_p0    = 64'd0;
                result_wr_p0 = 1'b1;
            end
        endcase
    end

    assign is_long_p0 = (MDUOp[2] == 1'b0);
    assign legal_p0   = (MDUOp <= OP_MTLO);
    assign accept_p0  = Start && !busy_q && legal_p0;

    // Stage 1: latch accepted ops, run the latency counter, commit to HI/LO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            pend_hi_p1 <= 32'd0;
            pend_lo_p1 <= 32'd0;
            pend_wr_p1 <= 1'b0;
        end else if (accept_p0) begin
            if (is_long_p0) begin
                cnt_q      <= MDUOp[1] ? DIV_LOAD : MULT_LOAD;
                busy_q     <= 1'b1;
                pend_hi_p1 <= result_p0[63:32];
                pend_lo_p1 <= result_p0[31:0];
                pend_wr_p1 <= result_wr_p0;
            end else if (MDUOp == OP_MTHI) begin
                hi_q <= A;
            end else begin
                lo_q <= A;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_ONE) begin
                busy_q <= 1'b0;
                if (pend_wr_p1) begin
                    hi_q <= pend_hi_p1;
                    lo_q <= pend_lo_p1;
                end
            end
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a vector table run back-to-back,
// plus hand sequences for reset mid-divide and Start while busy.
module tb_mul_div_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[15];

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .A(A),
        .B(B),
        .MDUOp(MDUOp),
        .Start(Start),
        .Busy(Busy),
        .HI(HI),
        .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pop the oldest expected result and compare against HI/LO.
    task automatic sb_check(input string name);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk_int({name, "_sb_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_hi"}, HI, e.hi);
            chk({name, "_lo"}, LO, e.lo);
        end
    endtask

    // Called at a negedge with Busy low; returns at the negedge Busy is low again.
    // Operands are scrambled every cycle after acceptance.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                         input int ecyc);
        int   n;
        exp_t e;
        MDUOp = op;
        A     = a;
        B     = b;
        Start = 1'b1;
        e.hi  = ehi;
        e.lo  = elo;
        sb_q.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            A     = $urandom;
            B     = $urandom;
            MDUOp = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        chk_int({name, "_cycles"}, n, ecyc);
        sb_check(name);
    endtask

    initial begin
        int   n;
        exp_t e;

        vecs[0]  = '{3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3]  = '{3'b011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10};
        vecs[4]  = '{3'b100, 32'h0000_1234, 32'h0000_9999, 32'h0000_1234, 32'h0000_0003, 0};
        vecs[5]  = '{3'b101, 32'h0000_5678, 32'h0000_9999, 32'h0000_1234, 32'h0000_5678, 0};
        vecs[6]  = '{3'b010, 32'h0000_0055, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 10};
        vecs[7]  = '{3'b011, 32'h0000_0009, 32'h0000_0000, 32'h0000_1234, 32'h0000_5678, 10};
        vecs[8]  = '{3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[9]  = '{3'b110, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_0000, 32'h8000_0000, 0};
        vecs[10] = '{3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[11] = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[12] = '{3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        vecs[13] = '{3'b010, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 10};
        vecs[14] = '{3'b111, 32'h0000_ABCD, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0003, 0};

        reset_n = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        MDUOp   = 3'b000;
        Start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table vectors issued back-to-back with no idle cycle between them.
        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // Reset while a DIV is in flight with four cycles left.
        MDUOp = 3'b010;
        A     = 32'd100;
        B     = 32'd7;
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_busy", {31'd0, Busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("postrst_hi", HI, 32'd0);
        chk("postrst_lo", LO, 32'd0);
        chk("postrst_busy", {31'd0, Busy}, 32'd0);

        // MULTU request while a DIV is busy must be dropped.
        MDUOp = 3'b010;
        A     = 32'd100;
        B     = 32'd7;
        Start = 1'b1;
        e.hi  = 32'd2;
        e.lo  = 32'd14;
        sb_q.push_back(e);
        @(negedge clk);
        Start = 1'b0;
        n = 0;
        while (Busy && n < 100) begin
            n++;
            if (n == 3) begin
                MDUOp = 3'b001;
                A     = 32'd3;
                B     = 32'd5;
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(negedge clk);
        end
        chk_int("ignored_cycles", n, 10);
        sb_check("ignored");

        // Start in the very cycle Busy falls is accepted.
        do_op("b2b_multu", 3'b001, 32'd3, 32'd5, 32'd0, 32'd15, 5);

        chk_int("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
